ps2_event_rx: RTL and testbench

PS/2 device-to-host receiver and scan-code-set-2 event decoder feeding the Lynx `keyboard` matrix stage. It filters the raw PS/2 clock and data lines, assembles and validates 11-bit frames, and resolves E0/F0/E1 prefixes. Each completed key transition leaves the block as a single-cycle event (code, extended, break). With the host-transmit option compiled in, it also drives keyboard LED updates back to the device.

---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_host_tx.sv | 131 +++++++++++++
 rtl/ps2_event_rx.sv | 196 +++++++++++++++++++
 tb/tb_ps2_event_rx.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 receiver shared definitions: protocol bytes,
// frame/TX state enums and the Pause skip length.
package ps2_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam logic [7:0] PS2_E1 = 8'hE1;
  localparam logic [7:0] PS2_AA = 8'hAA;
  localparam logic [7:0] PS2_FA = 8'hFA;
  localparam logic [7:0] PS2_FE = 8'hFE;
  localparam logic [7:0] PS2_ED = 8'hED;
  localparam logic [7:0] PS2_EE = 8'hEE;
  localparam logic [7:0] PS2_00 = 8'h00;
  localparam logic [7:0] PS2_FF = 8'hFF;

  localparam logic [7:0] PS2_PAUSE = 8'h77;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_DATA,
    FR_PARITY,
    FR_STOP
  } frame_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_REQ,
    TX_SHIFT,
    TX_ACK,
    TX_WAITFA
  } tx_state_t;

  function automatic logic is_silent(
    input logic [7:0] b
  );
    return b inside {PS2_FA, PS2_EE, PS2_FE,
                     PS2_00, PS2_FF};
  endfunction

endpackage

// File: rtl/ps2_host_tx.sv
// Host-to-device LED update sender (ED + LED byte, FA/FE handling).
// Ports: clock/reset_n/ce, fall+dat from rx, rx byte, led in, ps2_oe, rx_hold, consume. Built only with PS2_HOST_TX_EN.
`ifdef PS2_HOST_TX_EN
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_TICKS = 100,
  parameter int TIMEOUT_TICKS = 1000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       fall,
  input  logic       dat,
  input  logic       rx_idle,
  input  logic       rx_ok,
  input  logic [7:0] rx_byte,
  input  logic [2:0] led,
  output logic [1:0] ps2_oe,
  output logic       rx_hold,
  output logic       consume
);

  localparam int IW = $clog2(INHIBIT_TICKS + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  tx_state_t     st, st_nx;
  logic [IW-1:0] icnt;
  logic [TW-1:0] tcnt;
  logic [3:0]    bidx;
  logic [2:0]    led_sent, led_val;
  logic          idx, retried, tmo, live;
  logic [7:0]    txb;
  logic [15:0]   bits;

  assign txb  = idx ? {5'b0, led_val} : PS2_ED;
  assign bits = {6'h3F, 1'b1, ~^txb, txb};
  assign live = st inside {TX_REQ, TX_SHIFT,
                           TX_ACK, TX_WAITFA};
  assign tmo  = live & ce & ~fall &
                (tcnt == TW'(TIMEOUT_TICKS - 1));
  assign rx_hold = st inside {TX_INHIBIT, TX_REQ,
                              TX_SHIFT, TX_ACK};
  assign consume = (st == TX_WAITFA);

  always_comb begin
    ps2_oe = 2'b00;
    unique case (st)
      TX_INHIBIT: ps2_oe[0] = 1'b1;
      TX_REQ:     ps2_oe[1] = 1'b1;
      TX_SHIFT:   ps2_oe[1] = ~bits[bidx];
      default:    ;
    endcase
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      TX_IDLE:
        if (ce && rx_idle && led != led_sent)
          st_nx = TX_INHIBIT;
      TX_INHIBIT:
        if (ce && icnt == IW'(INHIBIT_TICKS - 1))
          st_nx = TX_REQ;
      TX_REQ:
        if (tmo) st_nx = TX_IDLE;
        else if (fall) st_nx = TX_SHIFT;
      TX_SHIFT:
        if (tmo) st_nx = TX_IDLE;
        else if (fall && bidx == 4'd9)
          st_nx = TX_ACK;
      TX_ACK:
        if (tmo) st_nx = TX_IDLE;
        else if (fall)
          st_nx = dat ? TX_IDLE : TX_WAITFA;
      TX_WAITFA:
        if (tmo) st_nx = TX_IDLE;
        else if (rx_ok) begin
          if (rx_byte == PS2_FA)
            st_nx = idx ? TX_IDLE : TX_INHIBIT;
          else if (rx_byte == PS2_FE && !retried)
            st_nx = TX_INHIBIT;
          else
            st_nx = TX_IDLE;
        end
      default: st_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) st <= TX_IDLE;
    else          st <= st_nx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_sent <= 3'b000;
      led_val  <= 3'b000;
      idx      <= 1'b0;
      retried  <= 1'b0;
      icnt     <= '0;
      tcnt     <= '0;
      bidx     <= 4'd0;
    end else begin
      if (st == TX_IDLE && st_nx == TX_INHIBIT) begin
        led_val  <= led;
        led_sent <= led;
        idx      <= 1'b0;
        retried  <= 1'b0;
      end
      if (st != TX_INHIBIT) icnt <= '0;
      else if (ce)          icnt <= icnt + 1'b1;
      if (fall)
        bidx <= (st == TX_SHIFT) ? bidx + 4'd1 : 4'd0;
      if (fall || !live)
        tcnt <= '0;
      else if (ce && tcnt != TW'(TIMEOUT_TICKS))
        tcnt <= tcnt + 1'b1;
      if (st == TX_WAITFA && rx_ok) begin
        if (rx_byte == PS2_FA) begin
          idx     <= 1'b1;
          retried <= 1'b0;
        end else if (rx_byte == PS2_FE) begin
          retried <= 1'b1;
        end
      end
    end
  end

endmodule
`endif

// File: rtl/ps2_event_rx.sv
// PS/2 receiver + set-2 decoder: clock filter, frame FSM, E0/F0/E1 prefix resolution, one-cycle key events.
// Ports: clock, reset_n, ce, ps2[1:0], ps2_oe, led, ev_*, err_*, bat_ok. Optional host TX: PS2_HOST_TX_EN.
module ps2_event_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN    = 8,
  parameter int TIMEOUT_TICKS = 1000,
  parameter int INHIBIT_TICKS = 100
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic [1:0] ps2_oe,
  input  logic [2:0] led,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       err_parity,
  output logic       err_frame,
  output logic       bat_ok
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);

  logic [FILTER_LEN-1:0] csr, csr_nx;
  logic                  clk_f, dat_q, fall;
  frame_state_t          st, st_nx;
  logic [2:0]            bcnt;
  logic [7:0]            sh;
  logic                  par;
  logic [TW-1:0]         tcnt;
  logic                  tmo, at_stop, stop_bad;
  logic                  par_bad, byte_ok, dec_ok;
  logic                  ext, brk;
  logic [2:0]            skip;
  logic                  rx_hold, consume;

  assign csr_nx = {csr[FILTER_LEN-2:0], ps2[0]};
  assign fall   = ce & clk_f & (csr_nx == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      csr   <= '1;
      clk_f <= 1'b1;
      dat_q <= 1'b1;
    end else if (ce) begin
      csr   <= csr_nx;
      dat_q <= ps2[1];
      if (&csr_nx)           clk_f <= 1'b1;
      else if (csr_nx == '0) clk_f <= 1'b0;
    end
  end

  assign tmo = ce & ~fall & (st != FR_IDLE) &
               (tcnt == TW'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      tcnt <= '0;
    else if (fall)
      tcnt <= '0;
    else if (ce && tcnt != TW'(TIMEOUT_TICKS))
      tcnt <= tcnt + 1'b1;
  end

  always_comb begin
    st_nx = st;
    if (rx_hold || tmo)
      st_nx = FR_IDLE;
    else if (fall) begin
      unique case (st)
        FR_IDLE:   if (!dat_q) st_nx = FR_DATA;
        FR_DATA:   if (bcnt == 3'd7) st_nx = FR_PARITY;
        FR_PARITY: st_nx = FR_STOP;
        FR_STOP:   st_nx = FR_IDLE;
        default:   st_nx = FR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) st <= FR_IDLE;
    else          st <= st_nx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bcnt <= 3'd0;
      sh   <= 8'h00;
      par  <= 1'b0;
    end else if (fall && !rx_hold) begin
      unique case (st)
        FR_IDLE: bcnt <= 3'd0;
        FR_DATA: begin
          sh   <= {dat_q, sh[7:1]};
          bcnt <= bcnt + 3'd1;
        end
        FR_PARITY: par <= dat_q;
        default: ;
      endcase
    end
  end

  // Odd parity: data ones plus parity bit must be odd.
  assign at_stop  = fall & ~rx_hold & (st == FR_STOP);
  assign stop_bad = at_stop & ~dat_q;
  assign par_bad  = at_stop & dat_q & ~(^sh ^ par);
  assign byte_ok  = at_stop & dat_q & (^sh ^ par);
  assign dec_ok   = byte_ok & ~consume;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ev_valid   <= 1'b0;
      ev_code    <= 8'h00;
      ev_ext     <= 1'b0;
      ev_break   <= 1'b0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      bat_ok     <= 1'b0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      skip       <= 3'd0;
    end else begin
      ev_valid   <= 1'b0;
      err_parity <= par_bad;
      err_frame  <= stop_bad | tmo;
      if (tmo) begin
        ext  <= 1'b0;
        brk  <= 1'b0;
        skip <= 3'd0;
      end else if (dec_ok) begin
        if (skip != 3'd0) begin
          // Pause has no break code: emit once at the end.
          skip <= skip - 3'd1;
          if (skip == 3'd1) begin
            ev_valid <= 1'b1;
            ev_code  <= PS2_PAUSE;
            ev_ext   <= 1'b1;
            ev_break <= 1'b0;
            ext      <= 1'b0;
            brk      <= 1'b0;
          end
        end else begin
          unique case (1'b1)
            (sh == PS2_E0): ext <= 1'b1;
            (sh == PS2_F0): brk <= 1'b1;
            (sh == PS2_E1): begin
              skip <= PAUSE_SKIP;
              ext  <= 1'b0;
              brk  <= 1'b0;
            end
            (sh == PS2_AA): bat_ok <= 1'b1;
            is_silent(sh): ;
            default: begin
              ev_valid <= 1'b1;
              ev_code  <= sh;
              ev_ext   <= ext;
              ev_break <= brk;
              ext      <= 1'b0;
              brk      <= 1'b0;
            end
          endcase
        end
      end
    end
  end

`ifdef PS2_HOST_TX_EN
  ps2_host_tx #(
    .INHIBIT_TICKS (INHIBIT_TICKS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) u_tx (
    .clock   (clock),
    .reset_n (reset_n),
    .ce      (ce),
    .fall    (fall),
    .dat     (dat_q),
    .rx_idle (st == FR_IDLE),
    .rx_ok   (byte_ok),
    .rx_byte (sh),
    .led     (led),
    .ps2_oe  (ps2_oe),
    .rx_hold (rx_hold),
    .consume (consume)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^{led, 32'(INHIBIT_TICKS)};
  assign ps2_oe  = 2'b00;
  assign rx_hold = 1'b0;
  assign consume = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_event_rx.sv
// Self-checking bench for ps2_event_rx: emulates a PS/2 device
// and checks decoded events against scan-code-set-2 rules.
module tb_ps2_event_rx;

  localparam int INH = 100;

  logic       clock, reset_n, ce;
  logic [1:0] ps2, ps2_oe;
  logic [2:0] led;
  logic       ev_valid, ev_ext, ev_break;
  logic [7:0] ev_code;
  logic       err_parity, err_frame, bat_ok;
  logic       dev_clk, dev_dat;

  int n_cmp, n_bad;
  int n_perr, n_ferr;
  bit oe_seen;
  logic [9:0] evq[$];

  assign ps2 = {dev_dat & ~ps2_oe[1], dev_clk & ~ps2_oe[0]};

  ps2_event_rx #(
    .FILTER_LEN    (8),
    .TIMEOUT_TICKS (1000),
    .INHIBIT_TICKS (INH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ce         (ce),
    .ps2        (ps2),
    .ps2_oe     (ps2_oe),
    .led        (led),
    .ev_valid   (ev_valid),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_break   (ev_break),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .bat_ok     (bat_ok)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    ce = 1'b0;
    forever begin
      @(negedge clock);
      ce = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (ev_valid)
        evq.push_back({ev_code, ev_ext, ev_break});
      if (err_parity) n_perr++;
      if (err_frame)  n_ferr++;
      if (ps2_oe != 2'b00) oe_seen = 1'b1;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic bit is_special(input logic [7:0] b);
    return b inside {8'hE0, 8'hF0, 8'hE1, 8'hAA,
                     8'hFA, 8'hEE, 8'hFE, 8'h00,
                     8'hFF};
  endfunction

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clock);
      #1;
      if (ce) k++;
    end
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit bad_par,
                            input bit bad_stop,
                            input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_dat = f[i];
      wait_ticks(8);
      dev_clk = 1'b0;
      wait_ticks(16);
      dev_clk = 1'b1;
      wait_ticks(8);
    end
    dev_dat = 1'b1;
    wait_ticks(24);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 11);
  endtask

  task automatic test_reset();
    logic [14:0] outs;
    outs = {ev_valid, ev_code, ev_ext, ev_break,
            err_parity, err_frame, bat_ok};
    n_cmp++;
    if (outs !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_outs got=%h want=0", outs);
    end
    n_cmp++;
    if (ps2_oe !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_oe got=%b want=00", ps2_oe);
    end
  endtask

  task automatic test_make_break();
    evq.delete();
    send(8'h1C);
    n_cmp++;
    if (evq.size() !== 1 || evq[0] !== {8'h1C, 2'b00}) begin
      n_bad++;
      $display("FAIL make n=%0d got=%h want=070",
               evq.size(), evq.size() ? evq[0] : 10'h0);
    end
    evq.delete();
    send(8'hF0);
    send(8'h1C);
    n_cmp++;
    if (evq.size() !== 1 || evq[0] !== {8'h1C, 2'b01}) begin
      n_bad++;
      $display("FAIL break n=%0d got=%h want=071",
               evq.size(), evq.size() ? evq[0] : 10'h0);
    end
    wait_ticks(50);
    n_cmp++;
    if ({ev_code, ev_ext, ev_break} !== {8'h1C, 2'b01}
        || ev_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold got=%h v=%b want=071 v=0",
               {ev_code, ev_ext, ev_break}, ev_valid);
    end
  endtask

  task automatic test_ext_break();
    evq.delete();
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    n_cmp++;
    if (evq.size() !== 1 || evq[0] !== {8'h75, 2'b11}) begin
      n_bad++;
      $display("FAIL ext_break n=%0d got=%h want=1d7",
               evq.size(), evq.size() ? evq[0] : 10'h0);
    end
  endtask

  task automatic test_parity();
    int p0;
    evq.delete();
    p0 = n_perr;
    send_frame(8'h16, 1'b1, 1'b0, 11);
    n_cmp++;
    if (n_perr - p0 !== 1 || evq.size() !== 0) begin
      n_bad++;
      $display("FAIL parity_err pulses=%0d ev=%0d want=1,0",
               n_perr - p0, evq.size());
    end
    send(8'h16);
    n_cmp++;
    if (evq.size() !== 1 || evq[0] !== {8'h16, 2'b00}) begin
      n_bad++;
      $display("FAIL parity_next n=%0d got=%h want=058",
               evq.size(), evq.size() ? evq[0] : 10'h0);
    end
  endtask

  task automatic test_frame_err();
    int f0;
    evq.delete();
    f0 = n_ferr;
    send_frame(8'h2B, 1'b0, 1'b1, 11);
    n_cmp++;
    if (n_ferr - f0 !== 1 || evq.size() !== 0) begin
      n_bad++;
      $display("FAIL stop_err pulses=%0d ev=%0d want=1,0",
               n_ferr - f0, evq.size());
    end
    send(8'hF0);
    f0 = n_ferr;
    send_frame(8'h29, 1'b0, 1'b0, 5);
    wait_ticks(1100);
    n_cmp++;
    if (n_ferr - f0 !== 1 || evq.size() !== 0) begin
      n_bad++;
      $display("FAIL timeout pulses=%0d ev=%0d want=1,0",
               n_ferr - f0, evq.size());
    end
    send(8'h29);
    n_cmp++;
    if (evq.size() !== 1 || evq[0] !== {8'h29, 2'b00}) begin
      n_bad++;
      $display("FAIL after_tmo n=%0d got=%h want=0a4",
               evq.size(), evq.size() ? evq[0] : 10'h0);
    end
  endtask

  task automatic test_pause_bat();
    logic [7:0] seq [8];
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1,
            8'hF0, 8'h14, 8'hF0, 8'h77};
    evq.delete();
    for (int i = 0; i < 8; i++) send(seq[i]);
    n_cmp++;
    if (evq.size() !== 1 || evq[0] !== {8'h77, 2'b10}) begin
      n_bad++;
      $display("FAIL pause n=%0d got=%h want=1de",
               evq.size(), evq.size() ? evq[0] : 10'h0);
    end
    n_cmp++;
    if (bat_ok !== 1'b0) begin
      n_bad++;
      $display("FAIL bat_pre got=%b want=0", bat_ok);
    end
    send(8'hAA);
    n_cmp++;
    if (bat_ok !== 1'b1 || evq.size() !== 1) begin
      n_bad++;
      $display("FAIL bat got=%b ev=%0d want=1,1",
               bat_ok, evq.size());
    end
  endtask

  task automatic test_silent();
    logic [7:0] s [5];
    s = '{8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    evq.delete();
    send(8'hE0);
    for (int i = 0; i < 5; i++) send(s[i]);
    n_cmp++;
    if (evq.size() !== 0) begin
      n_bad++;
      $display("FAIL silent ev=%0d want=0", evq.size());
    end
    send(8'h11);
    n_cmp++;
    if (evq.size() !== 1 || evq[0] !== {8'h11, 2'b10}) begin
      n_bad++;
      $display("FAIL silent_ext n=%0d got=%h want=046",
               evq.size(), evq.size() ? evq[0] : 10'h0);
    end
  endtask

  task automatic test_reset_mid();
    int p0, f0;
    logic [14:0] outs;
    evq.delete();
    send(8'hE0);
    send_frame(8'h1C, 1'b0, 1'b0, 5);
    p0 = n_perr;
    f0 = n_ferr;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    outs = {ev_valid, ev_code, ev_ext, ev_break,
            err_parity, err_frame, bat_ok};
    n_cmp++;
    if (outs !== 15'd0) begin
      n_bad++;
      $display("FAIL mid_reset got=%h want=0", outs);
    end
    reset_n = 1'b1;
    wait_ticks(20);
    send(8'h1C);
    n_cmp++;
    if (n_perr != p0 || n_ferr != f0 || evq.size() !== 1
        || evq[0] !== {8'h1C, 2'b00}) begin
      n_bad++;
      $display("FAIL mid_next pe=%0d fe=%0d n=%0d want=0,0,1",
               n_perr - p0, n_ferr - f0, evq.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      logic [7:0] c;
      bit e, b, swap;
      c = 8'($urandom_range(1, 254));
      while (is_special(c)) c = 8'($urandom_range(1, 254));
      e = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      swap = 1'($urandom_range(0, 1));
      evq.delete();
      if (swap) begin
        if (b) send(8'hF0);
        if (e) send(8'hE0);
      end else begin
        if (e) send(8'hE0);
        if (b) send(8'hF0);
      end
      send(c);
      n_cmp++;
      if (evq.size() !== 1 || evq[0] !== {c, e, b}) begin
        n_bad++;
        $display("FAIL rand%0d n=%0d got=%h want=%h", i,
                 evq.size(), evq.size() ? evq[0] : 10'h0,
                 {c, e, b});
      end
    end
  endtask

`ifdef PS2_HOST_TX_EN
  task automatic dev_rx_byte(input logic [7:0] b);
    int k, cnt;
    logic [10:0] got, want;
    k = 0;
    while (!ps2_oe[0] && k < 5000) begin
      @(posedge clock);
      #1;
      k++;
    end
    cnt = 0;
    k = 0;
    while (ps2_oe[0] && k < 5000) begin
      @(posedge clock);
      #1;
      if (ce) cnt++;
      k++;
    end
    n_cmp++;
    if (cnt < INH - 1 || cnt > INH + 1) begin
      n_bad++;
      $display("FAIL inhibit ticks=%0d want=%0d", cnt, INH);
    end
    n_cmp++;
    if (ps2_oe !== 2'b10) begin
      n_bad++;
      $display("FAIL req oe=%b want=10", ps2_oe);
    end
    wait_ticks(20);
    for (int i = 0; i < 11; i++) begin
      wait_ticks(8);
      got[i] = ps2[1];
      dev_clk = 1'b0;
      wait_ticks(16);
      dev_clk = 1'b1;
      wait_ticks(8);
    end
    want = {1'b1, ~^b, b, 1'b0};
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL tx_frame got=%b want=%b", got, want);
    end
    dev_dat = 1'b0;
    wait_ticks(8);
    dev_clk = 1'b0;
    wait_ticks(16);
    dev_clk = 1'b1;
    wait_ticks(8);
    dev_dat = 1'b1;
    wait_ticks(30);
    send(8'hFA);
  endtask

  task automatic test_tx();
    int p0, f0;
    evq.delete();
    p0 = n_perr;
    f0 = n_ferr;
    led = 3'b100;
    dev_rx_byte(8'hED);
    dev_rx_byte(8'h04);
    oe_seen = 1'b0;
    wait_ticks(300);
    n_cmp++;
    if (oe_seen || evq.size() !== 0 || n_perr != p0
        || n_ferr != f0) begin
      n_bad++;
      $display("FAIL tx_end oe=%b ev=%0d pe=%0d fe=%0d",
               oe_seen, evq.size(), n_perr - p0, n_ferr - f0);
    end
  endtask
`else
  task automatic test_tx();
    evq.delete();
    oe_seen = 1'b0;
    led = 3'b101;
    wait_ticks(400);
    n_cmp++;
    if (oe_seen || evq.size() !== 0) begin
      n_bad++;
      $display("FAIL no_tx oe=%b ev=%0d want=0,0",
               oe_seen, evq.size());
    end
    led = 3'b000;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_perr = 0;
    n_ferr = 0;
    oe_seen = 1'b0;
    reset_n = 1'b0;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    led = 3'b000;
    repeat (5) @(posedge clock);
    #1;
    test_reset();
    reset_n = 1'b1;
    wait_ticks(20);
    test_make_break();
    test_ext_break();
    test_parity();
    test_frame_err();
    test_pause_bat();
    test_silent();
    test_reset_mid();
    test_random();
    test_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
